// File: rtl/sha256_msg_sequencer.sv
// SHA-256 message sequencer: byte stream in, padded 512-bit blocks out to a
// compression core, chaining value carried between blocks, digest out.
module sha256_msg_sequencer #(
    parameter int CNT_W        = 61,
    parameter int CORE_TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    input  logic [7:0]   s_data,
    input  logic         s_last,
    output logic         s_ready,
    output logic         core_start,
    output logic [511:0] core_block,
    output logic [255:0] core_hin,
    input  logic [255:0] core_hout,
    input  logic         core_done,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy,
    output logic         error
);

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam int WD_W = (CORE_TIMEOUT > 1) ? $clog2(CORE_TIMEOUT + 1) : 2;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(CORE_TIMEOUT);
    localparam bit WD_EN = (CORE_TIMEOUT > 0);

    typedef enum logic [2:0] {
        IDLE, FILL, PAD, LEN, RUN, WAIT, DONE, ERR
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [0:63][7:0]   blk_q, blk_d;
    logic [255:0]       hin_q, hin_d;
    logic [255:0]       dig_q, dig_d;
    logic               dv_q, dv_d;
    logic               fin_q, fin_d;
    logic               pp_q, pp_d;
    logic               lp_q, lp_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               err_q, err_d;
    logic [63:0]        len64;
    logic               accept;

    assign len64   = 64'({cnt_q, 3'b000});
    assign s_ready = !rst && ((state_q == IDLE) ||
                     (state_q == FILL && idx_q < 7'd64));
    assign accept  = s_valid && s_ready;

    assign core_block   = blk_q;
    assign core_hin     = hin_q;
    assign digest       = dig_q;
    assign digest_valid = dv_q;
    assign error        = err_q;
    assign busy         = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        blk_d      = blk_q;
        hin_d      = hin_q;
        dig_d      = dig_q;
        dv_d       = 1'b0;
        fin_d      = fin_q;
        pp_d       = pp_q;
        lp_d       = lp_q;
        wd_d       = wd_q;
        err_d      = err_q;
        core_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    hin_d    = IV;
                    blk_d    = '0;
                    blk_d[0] = s_data;
                    idx_d    = 7'd1;
                    cnt_d    = CNT_W'(1);
                    fin_d    = 1'b0;
                    pp_d     = 1'b0;
                    lp_d     = 1'b0;
                    state_d  = s_last ? PAD : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    blk_d[idx_q[5:0]] = s_data;
                    idx_d = idx_q + 7'd1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (idx_q == 7'd63) begin
                        // A last byte that fills the block still owes a pad block
                        fin_d   = 1'b0;
                        pp_d    = s_last;
                        state_d = RUN;
                    end else if (s_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                for (int i = 0; i < 64; i++) begin
                    if (7'(i) == idx_q)
                        blk_d[i] = 8'h80;
                    else if (7'(i) > idx_q)
                        blk_d[i] = 8'h00;
                    if (idx_q <= 7'd55 && i >= 56)
                        blk_d[i] = len64[8*(63-i) +: 8];
                end
                fin_d   = (idx_q <= 7'd55);
                lp_d    = (idx_q > 7'd55);
                state_d = RUN;
            end
            LEN: begin
                blk_d = '0;
                for (int i = 56; i < 64; i++)
                    blk_d[i] = len64[8*(63-i) +: 8];
                fin_d   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                core_start = 1'b1;
                // The start cycle itself counts toward the timeout
                wd_d       = WD_W'(1);
                state_d    = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    hin_d = core_hout;
                    blk_d = '0;
                    idx_d = 7'd0;
                    if (fin_q) begin
                        state_d = DONE;
                    end else if (pp_q) begin
                        pp_d    = 1'b0;
                        state_d = PAD;
                    end else if (lp_q) begin
                        lp_d    = 1'b0;
                        state_d = LEN;
                    end else begin
                        state_d = FILL;
                    end
                end else if (WD_EN) begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d >= WD_LIM) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            DONE: begin
                dig_d   = hin_q;
                dv_d    = 1'b1;
                fin_d   = 1'b0;
                state_d = IDLE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            blk_q   <= '0;
            hin_q   <= IV;
            dig_q   <= '0;
            dv_q    <= 1'b0;
            fin_q   <= 1'b0;
            pp_q    <= 1'b0;
            lp_q    <= 1'b0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            hin_q   <= hin_d;
            dig_q   <= dig_d;
            dv_q    <= dv_d;
            fin_q   <= fin_d;
            pp_q    <= pp_d;
            lp_q    <= lp_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

endmodule
